// File: rtl/register_dump_reader_if.sv
// Read port toward the register file plus the valid/ready dump stream.
// The reader owns the master modport; the register file and the sink share the slave side.
interface register_dump_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] readAddress;
  logic [DATA_WIDTH-1:0] readData;
  logic [DATA_WIDTH-1:0] outData;
  logic [ADDR_WIDTH-1:0] outAddr;
  logic                  outLast;
  logic                  outValid;
  logic                  outReady;

  modport master (
    output readAddress,
    input  readData,
    output outData,
    output outAddr,
    output outLast,
    output outValid,
    input  outReady
  );

  modport slave (
    input  readAddress,
    output readData,
    input  outData,
    input  outAddr,
    input  outLast,
    input  outValid,
    output outReady
  );
endinterface

// File: rtl/register_dump_reader.sv
// Walks register addresses 0..COUNT-1 and streams each word, tagged with its address.
// Define REGDUMP_CHECKSUM_EN to append a modulo-2^DATA_WIDTH checksum word after the last register.
module register_dump_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int COUNT      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  register_dump_reader_if.master bus,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COUNT - 1);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, SUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic                  hs;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  assign hs = valid_q && bus.outReady;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      oaddr_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      last_q  <= last_d;
      valid_q <= valid_d;
`ifdef REGDUMP_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    last_d  = last_q;
    valid_d = valid_q;
`ifdef REGDUMP_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
`ifdef REGDUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = READ;
        end
      end
      READ: begin
        data_d  = bus.readData;
        oaddr_d = addr_q;
        valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        last_d  = 1'b0;
`else
        last_d  = (addr_q == LAST_ADDR);
`endif
        state_d = SEND;
      end
      SEND: begin
        if (hs) begin
          valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
          sum_d   = sum_q + data_q;
`endif
          // Terminal compare precedes the increment so addr never wraps.
          if (addr_q == LAST_ADDR) begin
`ifdef REGDUMP_CHECKSUM_EN
            // Checksum word follows back-to-back; valid stays high.
            data_d  = sum_q + data_q;
            oaddr_d = '0;
            last_d  = 1'b1;
            valid_d = 1'b1;
            state_d = SUM;
`else
            state_d = DONE;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = READ;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      SUM: begin
        if (hs) begin
          valid_d = 1'b0;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        // Park the read port at 0 and drop the stale last flag for the idle period.
        addr_d  = '0;
        last_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.readAddress = addr_q;
  assign bus.outData     = data_q;
  assign bus.outAddr     = oaddr_q;
  assign bus.outLast     = last_q;
  assign bus.outValid    = valid_q;
  assign busy            = (state_q != IDLE) && (state_q != DONE);
  assign done            = (state_q == DONE);

endmodule
